// File: rtl/pc_pkg.sv
// Shared widths and FSM state type for the program-counter / fetch controller.
package pc_pkg;
    localparam int PC_W  = 10;
    localparam int PTR_W = 5;
    localparam int OFF_W = 8;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: decoder/harness controls, LUT address/data and PC status outputs.
interface pc_fetch_ctrl_if;
    import pc_pkg::*;

    logic             Start;
    logic             Stall;
    logic             Halt;
    logic             BrRel;
    logic             BrAbs;
    logic             Taken;
    logic [PTR_W-1:0] BrPtr;
    logic [PTR_W-1:0] LutPtr;
    logic [OFF_W-1:0] LutDout;
    logic [PC_W-1:0]  PC;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstCnt;

    modport master (
        output Start, Stall, Halt, BrRel, BrAbs, Taken, BrPtr, LutDout,
        input  LutPtr, PC, Running, Done, InstCnt
    );

    modport slave (
        input  Start, Stall, Halt, BrRel, BrAbs, Taken, BrPtr, LutDout,
        output LutPtr, PC, Running, Done, InstCnt
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC: absolute target, signed relative offset, or sequential increment.
module pc_next_calc
    import pc_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] lut_dout,
    input  logic             br_abs,
    input  logic             br_rel,
    input  logic             taken,
    output logic [PC_W-1:0]  pc_next
);
    logic [PC_W-1:0] abs_target;
    logic [PC_W-1:0] rel_offset;

    // Size casts give zero-extension (unsigned) and sign-extension (signed),
    // truncating if PC_W is narrower; the sum then wraps mod 2^PC_W.
    assign abs_target = PC_W'(lut_dout);
    assign rel_offset = PC_W'($signed(lut_dout));

    always_comb begin
        pc_next = pc + PC_W'(1);
        if (taken && br_abs) begin
            pc_next = abs_target;
        end else if (taken && br_rel) begin
            pc_next = pc + rel_offset;
        end
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller FSM: sequences PC through IDLE/RUN/DONE and counts retired instructions.
module pc_fetch_ctrl
    import pc_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    pc_fetch_ctrl_if.slave   bus
);
    pc_state_t        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_inc;

    pc_next_calc u_next (
        .pc       (pc_q),
        .lut_dout (bus.LutDout),
        .br_abs   (bus.BrAbs),
        .br_rel   (bus.BrRel),
        .taken    (bus.Taken),
        .pc_next  (pc_nxt)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Stall freezes everything; otherwise each cycle retires one instruction.
                if (!bus.Stall) begin
                    cnt_d = cnt_inc;
                    if (bus.Halt) begin
                        state_d = DONE;
                    end else begin
                        pc_d = pc_nxt;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.LutPtr  = (state_q == RUN) ? bus.BrPtr : '0;
    assign bus.PC      = pc_q;
    assign bus.Running = running_q;
    assign bus.Done    = done_q;
    assign bus.InstCnt = cnt_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random stimulus against an arithmetic reference model.
module tb_pc_fetch_ctrl;
    logic Clk;
    logic Reset;

    pc_fetch_ctrl_if bus ();

    logic [7:0] lut_mem [32];
    assign bus.LutDout = lut_mem[bus.LutPtr];

    pc_fetch_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: mode 0 = idle, 1 = run, 2 = done
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;
    int last_lutptr = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, st, stl, hlt, rel, abs_, tkn, input int ptr);
        int off;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (!stl) begin
                m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                if (hlt) m_mode = 2;
                else if (abs_ && tkn) m_pc = int'(lut_mem[ptr]) % 1024;
                else if (rel && tkn) begin
                    off = int'(lut_mem[ptr]);
                    if (off > 127) off -= 256;
                    m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
                end else m_pc = (m_pc + 1) % 1024;
            end
        end else if (st) begin
            m_mode = 1; m_pc = 0; m_cnt = 0;
        end
    endtask

    task automatic cycle(input bit rst, st, stl, hlt, rel, abs_, tkn, input int ptr);
        Reset     = rst;
        bus.Start = st;
        bus.Stall = stl;
        bus.Halt  = hlt;
        bus.BrRel = rel;
        bus.BrAbs = abs_;
        bus.Taken = tkn;
        bus.BrPtr = 5'(ptr);
        #1;
        last_lutptr = int'(bus.LutPtr);
        chk("lutptr", bus.LutPtr, (m_mode == 1) ? ptr : 0);
        model_step(rst, st, stl, hlt, rel, abs_, tkn, ptr);
        @(posedge Clk);
        #1;
        chk("pc", bus.PC, m_pc);
        chk("running", bus.Running, m_mode == 1);
        chk("done", bus.Done, m_mode == 2);
        chk("instcnt", bus.InstCnt, m_cnt);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int cnt_before;

    initial begin
        for (int i = 0; i < 32; i++) lut_mem[i] = 8'h00;
        lut_mem[1] = 8'hF5;
        lut_mem[2] = 8'd20;
        lut_mem[3] = 8'd1;
        lut_mem[4] = 8'd37;
        Reset = 1'b1;
        bus.Start = 0; bus.Stall = 0; bus.Halt = 0;
        bus.BrRel = 0; bus.BrAbs = 0; bus.Taken = 0; bus.BrPtr = '0;
        @(posedge Clk);
        #1;

        // reset for two cycles, then Start
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", bus.PC, 0);
        chk("rst_running", bus.Running, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_cnt", bus.InstCnt, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        chk("t1_running", bus.Running, 1);
        chk("t1_pc0", bus.PC, 0);
        plain(3);
        chk("t1_pc3", bus.PC, 3);
        chk("t1_cnt3", bus.InstCnt, 3);

        // relative branch taken / not taken from PC=20
        cycle(0, 0, 0, 0, 0, 1, 1, 2);
        chk("t2_pc20", bus.PC, 20);
        cycle(0, 0, 0, 0, 1, 0, 1, 1);
        chk("t2_lutptr", last_lutptr, 1);
        chk("t2_pc9", bus.PC, 9);
        cycle(0, 0, 0, 0, 0, 1, 1, 2);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        chk("t2_pc21", bus.PC, 21);

        // wrap both directions
        cycle(0, 0, 0, 0, 0, 1, 1, 3);
        cycle(0, 0, 0, 0, 1, 0, 1, 1);
        chk("t3_pc1014", bus.PC, 1014);
        plain(9);
        chk("t3_pc1023", bus.PC, 1023);
        plain(1);
        chk("t3_pc0", bus.PC, 0);

        // absolute wins over relative, zero-extended
        cnt_before = int'(bus.InstCnt);
        cycle(0, 0, 0, 0, 1, 1, 1, 1);
        chk("t4_pc245", bus.PC, 245);
        chk("t4_cnt", bus.InstCnt, cnt_before + 1);

        // stall masks halt, then halt, then restart
        cycle(0, 0, 0, 0, 0, 1, 1, 4);
        cnt_before = int'(bus.InstCnt);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0, 0, 0);
        chk("t5_pc_frozen", bus.PC, 37);
        chk("t5_cnt_frozen", bus.InstCnt, cnt_before);
        chk("t5_done0", bus.Done, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        chk("t5_done1", bus.Done, 1);
        chk("t5_pc_hold", bus.PC, 37);
        chk("t5_cnt_inc", bus.InstCnt, cnt_before + 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_done_hold", bus.Done, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        chk("t5_restart_pc", bus.PC, 0);
        chk("t5_restart_cnt", bus.InstCnt, 0);
        chk("t5_restart_done", bus.Done, 0);
        chk("t5_restart_run", bus.Running, 1);

        // reset mid-RUN while stalled
        cycle(0, 0, 0, 0, 0, 1, 1, 4);
        chk("t6_pc37", bus.PC, 37);
        cycle(1, 0, 1, 0, 0, 0, 0, 4);
        chk("t6_pc0", bus.PC, 0);
        chk("t6_cnt0", bus.InstCnt, 0);
        chk("t6_running0", bus.Running, 0);
        chk("t6_done0", bus.Done, 0);
        chk("t6_lutptr0", bus.LutPtr, 0);

        // random phase
        for (int i = 0; i < 32; i++) lut_mem[i] = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 19) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
